// File: rtl/pipe_seq_if.sv
// Sequencer <-> datapath bundle: hazard/redirect inputs in, stall/flush/trace-tag outputs back.
// Handshake: there is no valid/ready pair; every output is a per-cycle strobe or tag, sampled each cycle.
interface pipe_seq_if #(
  parameter int ID_W = 32
);
  logic            fetch_v;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic            use_rs1_i;
  logic            use_rs2_i;
  logic            ld_x;
  logic [4:0]      rd_x;
  logic            redirect;
  logic            mem_busy;
  logic            stall_i;
  logic            flush;
  logic            kill_v;
  logic [ID_W-1:0] kill_id;
  logic            inst_v_i;
  logic            inst_v_x;
  logic            inst_v_m;
  logic            inst_v_r;
  logic [ID_W-1:0] ci;
  logic [ID_W-1:0] cx;
  logic [ID_W-1:0] cm;
  logic [ID_W-1:0] cr;
  logic [ID_W-1:0] retired;

  modport master (
    output fetch_v, rs1_i, rs2_i, use_rs1_i, use_rs2_i, ld_x, rd_x, redirect, mem_busy,
    input  stall_i, flush, kill_v, kill_id, inst_v_i, inst_v_x, inst_v_m, inst_v_r,
           ci, cx, cm, cr, retired
  );

  modport slave (
    input  fetch_v, rs1_i, rs2_i, use_rs1_i, use_rs2_i, ld_x, rd_x, redirect, mem_busy,
    output stall_i, flush, kill_v, kill_id, inst_v_i, inst_v_x, inst_v_m, inst_v_r,
           ci, cx, cm, cr, retired
  );
endinterface

// File: rtl/pipe_seq.sv
// Issue/stall/flush sequencer for the I-X-M-R pipeline; tracks per-stage valid bits and IDs
// and emits stage-entry, kill and retire events for the trace logger.
module pipe_seq #(
  parameter int ID_W = 32
) (
  input  logic     clk,
  input  logic     reset,
  pipe_seq_if.slave bus
);

  logic [ID_W-1:0] next_id_q, next_id_d;
  logic            i_logged_q, i_logged_d;
  logic            valid_x_q, valid_x_d;
  logic            valid_m_q, valid_m_d;
  logic            valid_r_q, valid_r_d;
  logic [ID_W-1:0] id_x_q, id_x_d;
  logic [ID_W-1:0] id_m_q, id_m_d;
  logic [ID_W-1:0] id_r_q, id_r_d;
  logic            ent_x_q, ent_x_d;
  logic            ent_m_q, ent_m_d;
  logic            ent_r_q, ent_r_d;
  logic [ID_W-1:0] retired_q, retired_d;

  logic adv;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic flush_c;
  logic take;
  logic kill_c;

  always_comb begin
    adv      = !bus.mem_busy;
    rs1_hit  = bus.use_rs1_i && (bus.rs1_i == bus.rd_x);
    rs2_hit  = bus.use_rs2_i && (bus.rs2_i == bus.rd_x);
    load_use = valid_x_q && bus.ld_x && (bus.rd_x != 5'd0) && (rs1_hit || rs2_hit);
    // A redirect only counts once the pipe can move, so it waits out mem_busy.
    flush_c  = bus.redirect && valid_x_q && adv;
    take     = bus.fetch_v && adv && !load_use && !flush_c;
    kill_c   = flush_c && bus.fetch_v;
  end

  always_comb begin
    next_id_d  = next_id_q;
    i_logged_d = i_logged_q;
    valid_x_d  = valid_x_q;
    valid_m_d  = valid_m_q;
    valid_r_d  = valid_r_q;
    id_x_d     = id_x_q;
    id_m_d     = id_m_q;
    id_r_d     = id_r_q;
    ent_x_d    = 1'b0;
    ent_m_d    = 1'b0;
    ent_r_d    = 1'b0;
    retired_d  = retired_q + ID_W'(ent_r_q);

    // Each ID is consumed exactly once, by issue or by kill.
    if (take || kill_c) begin
      next_id_d  = next_id_q + 1'b1;
      i_logged_d = 1'b0;
    end else if (bus.fetch_v) begin
      i_logged_d = 1'b1;
    end

    if (adv) begin
      valid_r_d = valid_m_q;
      id_r_d    = id_m_q;
      valid_m_d = valid_x_q;
      id_m_d    = id_x_q;
      valid_x_d = take;
      id_x_d    = next_id_q;
      ent_x_d   = take;
      ent_m_d   = valid_x_q;
      ent_r_d   = valid_m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      next_id_q  <= '0;
      i_logged_q <= 1'b0;
      valid_x_q  <= 1'b0;
      valid_m_q  <= 1'b0;
      valid_r_q  <= 1'b0;
      id_x_q     <= '0;
      id_m_q     <= '0;
      id_r_q     <= '0;
      ent_x_q    <= 1'b0;
      ent_m_q    <= 1'b0;
      ent_r_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      next_id_q  <= next_id_d;
      i_logged_q <= i_logged_d;
      valid_x_q  <= valid_x_d;
      valid_m_q  <= valid_m_d;
      valid_r_q  <= valid_r_d;
      id_x_q     <= id_x_d;
      id_m_q     <= id_m_d;
      id_r_q     <= id_r_d;
      ent_x_q    <= ent_x_d;
      ent_m_q    <= ent_m_d;
      ent_r_q    <= ent_r_d;
      retired_q  <= retired_d;
    end
  end

  assign bus.stall_i  = bus.fetch_v && (bus.mem_busy || load_use) && !flush_c;
  assign bus.flush    = flush_c;
  assign bus.kill_v   = kill_c;
  assign bus.kill_id  = next_id_q;
  assign bus.inst_v_i = bus.fetch_v && !i_logged_q;
  assign bus.ci       = next_id_q;
  assign bus.inst_v_x = ent_x_q;
  assign bus.inst_v_m = ent_m_q;
  assign bus.inst_v_r = ent_r_q;
  assign bus.cx       = id_x_q;
  assign bus.cm       = id_m_q;
  assign bus.cr       = id_r_q;
  assign bus.retired  = retired_q;

endmodule
